bsg_front_side_bus_hop_out_rr: RTL and testbench

//  Fan-in side of a front side bus hop. Merges fan_in_p valid/ready requesters onto one FSB output

---
 rtl/bsg_front_side_bus_hop_out_rr.sv | 124 ++++++++++++
 tb/tb_bsg_front_side_bus_hop_out_rr.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_front_side_bus_hop_out_rr.sv
// Round-robin fan-in merge onto one FSB output link, with optional multi-beat grant
// locking and a 2-entry output FIFO (two-fifo semantics: ready only while not full).
// state  | meaning
// IDLE   | arbitrate every beat, scanning from ptr_q
// LOCKED | owner_q holds the link until lock_len_p beats are accepted
module bsg_front_side_bus_hop_out_rr #(
    parameter int width_p    = 16,
    parameter int fan_in_p   = 2,
    parameter int lock_len_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fan_in_p-1:0]          v_i,
    input  logic [fan_in_p*width_p-1:0]  data_i,
    output logic [fan_in_p-1:0]          ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i
);

    localparam int ptr_w_lp = (fan_in_p > 1) ? $clog2(fan_in_p) : 1;
    localparam int cnt_w_lp = (lock_len_p > 1) ? $clog2(lock_len_p) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [ptr_w_lp-1:0]   ptr_q, ptr_d;
    logic [ptr_w_lp-1:0]   owner_q, owner_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;

    logic [width_p-1:0]    mem_q [2];
    logic                  wr_q, rd_q, full_q, empty_q;

    logic                  fifo_ready, enq, deq, found;
    logic [ptr_w_lp-1:0]   win, sel;
    logic [width_p-1:0]    enq_data;
    int                    idx;

    assign fifo_ready = ~full_q;
    assign deq        = ~empty_q & ready_i;
    assign v_o        = ~empty_q;
    assign data_o     = mem_q[rd_q];

    always_comb begin
        found    = 1'b0;
        win      = ptr_q;
        idx      = 0;
        for (int k = 0; k < fan_in_p; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= fan_in_p) idx = idx - fan_in_p;
            if (!found && v_i[idx]) begin
                found = 1'b1;
                win   = ptr_w_lp'(idx);
            end
        end

        sel     = (state_q == LOCKED) ? owner_q : win;
        ready_o = '0;
        // Locked owner is offered the slot even while it is not presenting a beat.
        if (!reset_i && fifo_ready && (state_q == LOCKED || found))
            ready_o[sel] = 1'b1;
        enq      = v_i[sel] & ready_o[sel];
        enq_data = data_i[sel*width_p +: width_p];

        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (enq) begin
            case (state_q)
                IDLE: begin
                    ptr_d = (int'(win) == fan_in_p-1) ? '0 : win + ptr_w_lp'(1);
                    if (lock_len_p > 1) begin
                        state_d = LOCKED;
                        owner_d = win;
                        cnt_d   = cnt_w_lp'(1);
                    end
                end
                LOCKED: begin
                    if (cnt_q == cnt_w_lp'(lock_len_p-1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_w_lp'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (enq) wr_q <= ~wr_q;
            if (deq) rd_q <= ~rd_q;
            // Occupancy is 1 exactly when the pointers differ.
            if (enq && !deq) begin
                empty_q <= 1'b0;
                full_q  <= (wr_q != rd_q);
            end else if (deq && !enq) begin
                full_q  <= 1'b0;
                empty_q <= (wr_q != rd_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_q] <= enq_data;
    end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_rr.sv
// Bench for bsg_front_side_bus_hop_out_rr: three configurations (2/1, 2/3, 3/2 fan-in/lock)
// with directed scenarios and a randomized run against a queue-style reference model.
module tb_bsg_front_side_bus_hop_out_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  v [3];
    logic [47:0] d [3];
    logic        ri [3];

    logic [1:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic        vo0, vo1, vo2;
    logic [15:0] do0, do1, do2;

    logic [2:0]  rdy_a [3];
    logic        vo_a [3];
    logic [15:0] do_a [3];

    int total = 0;
    int bad   = 0;

    localparam int FAN  [3] = '{2, 2, 3};
    localparam int LOCK [3] = '{1, 3, 2};

    int          m_prio [3];
    int          m_owner[3];
    int          m_left [3];
    int          m_cnt  [3];
    logic [15:0] m_q    [3][2];

    always #5 clk = ~clk;

    bsg_front_side_bus_hop_out_rr #(.width_p(16), .fan_in_p(2), .lock_len_p(1)) u0 (
        .clk_i(clk), .reset_i(reset), .v_i(v[0][1:0]), .data_i(d[0][31:0]),
        .ready_o(rdy0), .v_o(vo0), .data_o(do0), .ready_i(ri[0]));
    bsg_front_side_bus_hop_out_rr #(.width_p(16), .fan_in_p(2), .lock_len_p(3)) u1 (
        .clk_i(clk), .reset_i(reset), .v_i(v[1][1:0]), .data_i(d[1][31:0]),
        .ready_o(rdy1), .v_o(vo1), .data_o(do1), .ready_i(ri[1]));
    bsg_front_side_bus_hop_out_rr #(.width_p(16), .fan_in_p(3), .lock_len_p(2)) u2 (
        .clk_i(clk), .reset_i(reset), .v_i(v[2]), .data_i(d[2]),
        .ready_o(rdy2), .v_o(vo2), .data_o(do2), .ready_i(ri[2]));

    assign rdy_a[0] = {1'b0, rdy0};
    assign rdy_a[1] = {1'b0, rdy1};
    assign rdy_a[2] = rdy2;
    assign vo_a[0]  = vo0;
    assign vo_a[1]  = vo1;
    assign vo_a[2]  = vo2;
    assign do_a[0]  = do0;
    assign do_a[1]  = do1;
    assign do_a[2]  = do2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_prio[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k] = '0; d[k] = '0; ri[k] = 1'b0;
        end
        step();
        reset = 1'b0;
        model_clear();
    endtask

    // Expected grant: nothing while resetting or with both slots taken; the lock owner
    // if a lock is running; otherwise the first valid requester at or after the priority slot.
    function automatic logic [2:0] model_ready(int k);
        logic [2:0] r;
        int         j;
        r = '0;
        if (reset || m_cnt[k] == 2) return r;
        if (m_left[k] > 0) begin
            r[m_owner[k]] = 1'b1;
            return r;
        end
        for (int o = 0; o < FAN[k]; o++) begin
            j = (m_prio[k] + o) % FAN[k];
            if (v[k][j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_clock(int k, logic [2:0] er);
        int w;
        logic hit;
        if (reset) begin
            m_prio[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
            return;
        end
        hit = 1'b0;
        w   = 0;
        for (int j = 0; j < FAN[k]; j++)
            if (er[j] && v[k][j]) begin hit = 1'b1; w = j; end
        if (m_cnt[k] > 0 && ri[k]) begin
            m_q[k][0] = m_q[k][1];
            m_cnt[k]  = m_cnt[k] - 1;
        end
        if (hit) begin
            m_q[k][m_cnt[k]] = d[k][w*16 +: 16];
            m_cnt[k] = m_cnt[k] + 1;
            if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
            end else begin
                m_prio[k] = (w + 1) % FAN[k];
                if (LOCK[k] > 1) begin
                    m_owner[k] = w;
                    m_left[k]  = LOCK[k] - 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k] = 3'b111; d[k] = 48'h123456789abc; ri[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_a[k] !== 3'b000) begin
                bad++; $display("FAIL reset_ready dut%0d got=%b want=000", k, rdy_a[k]);
            end
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) v[k] = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (vo_a[k] !== 1'b0 || rdy_a[k] !== 3'b000) begin
                bad++; $display("FAIL reset_state dut%0d v_o=%b ready=%b want v_o=0 ready=000", k, vo_a[k], rdy_a[k]);
            end
        end
        model_clear();
    endtask

    task automatic test_rotation();
        logic [15:0] prev;
        do_reset();
        ri[0] = 1'b1;
        v[0]  = 3'b011;
        prev  = '0;
        for (int c = 0; c < 6; c++) begin
            d[0] = {16'h0, 16'hb000 + 16'(c), 16'ha000 + 16'(c)};
            #1;
            total++;
            if (rdy0 !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rotation_grant c=%0d got=%b want=%b", c, rdy0, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            total++;
            if (vo0 !== (c > 0) || (c > 0 && do0 !== prev)) begin
                bad++; $display("FAIL rotation_out c=%0d v_o=%b data=%h want v_o=%0d data=%h", c, vo0, do0, c > 0, prev);
            end
            prev = (c % 2 == 0) ? 16'ha000 + 16'(c) : 16'hb000 + 16'(c);
            step();
        end
        v[0] = '0;
    endtask

    task automatic test_backpressure();
        logic [1:0]  want_r [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [15:0] want_d [6] = '{16'h0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        logic        want_v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] pres   [6] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hCCCC, 16'hCCCC, 16'h0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            ri[0] = (c >= 3);
            v[0]  = (c < 5) ? 3'b001 : 3'b000;
            d[0]  = {32'h0, pres[c]};
            #1;
            total++;
            if (rdy0 !== (c < 5 ? want_r[c] : 2'b00)) begin
                bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, rdy0, want_r[c]);
            end
            total++;
            if (vo0 !== want_v[c] || (want_v[c] && do0 !== want_d[c])) begin
                bad++; $display("FAIL bp_out c=%0d v_o=%b data=%h want v_o=%b data=%h", c, vo0, do0, want_v[c], want_d[c]);
            end
            step();
        end
        v[0] = '0;
    endtask

    task automatic test_lock();
        logic [1:0] want_a [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [1:0] vin_b  [6] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
        logic [1:0] want_b [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        do_reset();
        ri[1] = 1'b1;
        v[1]  = 3'b011;
        for (int c = 0; c < 7; c++) begin
            #1;
            total++;
            if (rdy1 !== want_a[c]) begin
                bad++; $display("FAIL lock_rotate c=%0d got=%b want=%b", c, rdy1, want_a[c]);
            end
            step();
        end
        do_reset();
        ri[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            v[1] = {1'b0, vin_b[c]};
            #1;
            total++;
            if (rdy1 !== want_b[c]) begin
                bad++; $display("FAIL lock_hold c=%0d got=%b want=%b", c, rdy1, want_b[c]);
            end
            step();
        end
        v[1] = '0;
    endtask

    task automatic test_wrap();
        logic [2:0] vin  [5] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b011};
        logic [2:0] want [5] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b010};
        do_reset();
        ri[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            v[2] = vin[c];
            #1;
            total++;
            if (rdy2 !== want[c]) begin
                bad++; $display("FAIL wrap_grant c=%0d got=%b want=%b", c, rdy2, want[c]);
            end
            step();
        end
        v[2] = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        v[1] = 3'b011;
        d[1] = {32'h0, 16'h5a5a};
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (rdy1 !== (c < 2 ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL midrst_fill c=%0d got=%b want=%b", c, rdy1, c < 2 ? 2'b01 : 2'b00);
            end
            if (c < 2) step();
        end
        reset = 1'b1;
        #1;
        total++;
        if (rdy1 !== 2'b00) begin
            bad++; $display("FAIL midrst_during got=%b want=00", rdy1);
        end
        step();
        reset = 1'b0;
        ri[1] = 1'b1;
        #1;
        total++;
        if (vo1 !== 1'b0 || rdy1 !== 2'b01) begin
            bad++; $display("FAIL midrst_after v_o=%b ready=%b want v_o=0 ready=01", vo1, rdy1);
        end
        step();
        total++;
        if (vo1 !== 1'b1 || do1 !== 16'h5a5a || rdy1 !== 2'b01) begin
            bad++; $display("FAIL midrst_restart v_o=%b data=%h ready=%b want 1 5a5a 01", vo1, do1, rdy1);
        end
        v[1] = '0;
        model_clear();
    endtask

    task automatic test_random();
        logic [2:0] er [3];
        logic [2:0] mask;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(199) == 0);
            for (int k = 0; k < 3; k++) begin
                mask  = (FAN[k] == 3) ? 3'b111 : 3'b011;
                v[k]  = 3'($urandom) & mask;
                d[k]  = {16'($urandom), 32'($urandom)};
                ri[k] = ($urandom_range(3) != 0);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                er[k] = model_ready(k);
                total++;
                if (rdy_a[k] !== er[k]) begin
                    bad++; $display("FAIL rand_ready dut%0d c=%0d got=%b want=%b", k, c, rdy_a[k], er[k]);
                end
                total++;
                if (vo_a[k] !== (m_cnt[k] > 0) || (m_cnt[k] > 0 && do_a[k] !== m_q[k][0])) begin
                    bad++; $display("FAIL rand_out dut%0d c=%0d v_o=%b data=%h want v_o=%0d data=%h",
                                    k, c, vo_a[k], do_a[k], m_cnt[k] > 0, m_q[k][0]);
                end
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) model_clock(k, er[k]);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k] = '0; d[k] = '0; ri[k] = 1'b0;
        end
        step();
        test_reset();
        test_rotation();
        test_backpressure();
        test_lock();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
